// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace buffer: FSM state encoding and the stored
// per-retirement record layout.
package ibex_trace_pkg;

    typedef enum logic [1:0] {
        TR_IDLE = 2'd0,
        TR_PRE  = 2'd1,
        TR_POST = 2'd2,
        TR_DONE = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        trap;
        logic        intr;
    } trace_rec_t;

    localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_ring_mem.sv
// Ring storage for trace records: one synchronous write port, one
// asynchronous read port, no reset on the array.
module trace_ring_mem
    import ibex_trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [TRACE_REC_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]      raddr_i,
    output logic [TRACE_REC_W-1:0] rdata_o
);

    logic [TRACE_REC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Post-mortem retirement trace: captures RVFI records into a ring around a
// trigger, freezes, then drains oldest-first over a valid/ready port.
module rvfi_trace_buffer
    import ibex_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned POST_TRIG = 16,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rvfi_valid_i,
    input  logic [63:0]      rvfi_order_i,
    input  logic [31:0]      rvfi_pc_rdata_i,
    input  logic [31:0]      rvfi_insn_i,
    input  logic             rvfi_trap_i,
    input  logic             rvfi_intr_i,
    input  logic [4:0]       rvfi_rd_addr_i,
    input  logic [31:0]      rvfi_rd_wdata_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_pc_en_i,
    input  logic [31:0]      trig_pc_i,
    input  logic             trig_on_trap_i,
    input  logic             force_trig_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output trace_rec_t       rd_data_o,
    output logic [1:0]       state_o,
    output logic             triggered_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic [63:0]      trig_order_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    trace_state_e     state_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] post_cnt_q;
    logic [CNT_W-1:0] count_q;
    logic             triggered_q;
    logic [63:0]      trig_order_q;
    logic [63:0]      last_order_q;

    logic             wr_en;
    logic             fire;
    logic             enter_done;
    logic             rd_valid;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [CNT_W-1:0] count_wr;
    trace_rec_t       wr_rec;
    trace_rec_t       rd_rec;

    always_comb begin
        wr_en = (state_q == TR_PRE || state_q == TR_POST) && rvfi_valid_i && !abort_i;
        fire  = (state_q == TR_PRE) &&
                (force_trig_i ||
                 (rvfi_valid_i && trig_pc_en_i && rvfi_pc_rdata_i == trig_pc_i) ||
                 (rvfi_valid_i && trig_on_trap_i && rvfi_trap_i));
        wr_ptr_nxt = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_wr   = count_q;
        if (wr_en && count_q != CNT_W'(DEPTH)) begin
            count_wr = count_q + CNT_W'(1);
        end
        // The transition into DONE must see this cycle's write so rd_ptr lands on the oldest entry.
        enter_done = (fire && POST_TRIG == 0) ||
                     (state_q == TR_POST && rvfi_valid_i && post_cnt_q == PTR_W'(1));
        rd_valid = (state_q == TR_DONE) && (count_q != '0);
        pop      = rd_valid && rd_ready_i;
    end

    always_comb begin
        wr_rec.pc       = rvfi_pc_rdata_i;
        wr_rec.insn     = rvfi_insn_i;
        wr_rec.rd_addr  = rvfi_rd_addr_i;
        wr_rec.rd_wdata = rvfi_rd_wdata_i;
        wr_rec.trap     = rvfi_trap_i;
        wr_rec.intr     = rvfi_intr_i;
    end

    trace_ring_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_rec),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_rec)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= TR_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            post_cnt_q   <= '0;
            count_q      <= '0;
            triggered_q  <= 1'b0;
            trig_order_q <= '0;
            last_order_q <= '0;
        end else if (abort_i) begin
            state_q      <= TR_IDLE;
            count_q      <= '0;
            triggered_q  <= 1'b0;
            trig_order_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q     <= wr_ptr_nxt;
                count_q      <= count_wr;
                last_order_q <= rvfi_order_i;
            end
            case (state_q)
                TR_IDLE: begin
                    if (arm_i) begin
                        state_q      <= TR_PRE;
                        wr_ptr_q     <= '0;
                        count_q      <= '0;
                        triggered_q  <= 1'b0;
                        trig_order_q <= '0;
                        last_order_q <= '0;
                    end
                end
                TR_PRE: begin
                    if (fire) begin
                        triggered_q  <= 1'b1;
                        trig_order_q <= rvfi_valid_i ? rvfi_order_i : last_order_q;
                        post_cnt_q   <= PTR_W'(POST_TRIG);
                        state_q      <= TR_POST;
                    end
                end
                TR_POST: begin
                    if (rvfi_valid_i) begin
                        post_cnt_q <= post_cnt_q - PTR_W'(1);
                    end
                end
                TR_DONE: begin
                    if (count_q == '0) begin
                        state_q <= TR_IDLE;
                    end else if (pop) begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        count_q  <= count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            state_q <= TR_IDLE;
                        end
                    end
                end
                default: state_q <= TR_IDLE;
            endcase
            if (enter_done) begin
                state_q  <= TR_DONE;
                rd_ptr_q <= wr_ptr_nxt - count_wr[PTR_W-1:0];
            end
        end
    end

    assign rd_valid_o   = rd_valid;
    assign rd_data_o    = rd_valid ? rd_rec : '0;
    assign state_o      = state_q;
    assign triggered_o  = triggered_q;
    assign done_o       = (state_q == TR_DONE);
    assign count_o      = count_q;
    assign trig_order_o = trig_order_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Self-checking bench for rvfi_trace_buffer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_rvfi_trace_buffer;
    import ibex_trace_pkg::*;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned POST_TRIG = 2;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 0, trap = 0, intr = 0, arm = 0, abort = 0;
    logic pc_en = 0, trap_en = 0, frc = 0, ready = 0;
    logic [63:0] order = '0;
    logic [31:0] pc = '0, insn = '0, rd_wdata = '0, tpc = '0;
    logic [4:0]  rd_addr = '0;

    logic             rd_valid;
    trace_rec_t       rd_data;
    logic [1:0]       state;
    logic             triggered;
    logic             done;
    logic [CNT_W-1:0] count;
    logic [63:0]      trig_order;

    always #5 clk = ~clk;

    rvfi_trace_buffer #(
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rvfi_valid_i    (valid),
        .rvfi_order_i    (order),
        .rvfi_pc_rdata_i (pc),
        .rvfi_insn_i     (insn),
        .rvfi_trap_i     (trap),
        .rvfi_intr_i     (intr),
        .rvfi_rd_addr_i  (rd_addr),
        .rvfi_rd_wdata_i (rd_wdata),
        .arm_i           (arm),
        .abort_i         (abort),
        .trig_pc_en_i    (pc_en),
        .trig_pc_i       (tpc),
        .trig_on_trap_i  (trap_en),
        .force_trig_i    (frc),
        .rd_ready_i      (ready),
        .rd_valid_o      (rd_valid),
        .rd_data_o       (rd_data),
        .state_o         (state),
        .triggered_o     (triggered),
        .done_o          (done),
        .count_o         (count),
        .trig_order_o    (trig_order)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0=IDLE 1=PRE 2=POST 3=DONE, captured records as a queue
    int          m_state = 0;
    trace_rec_t  m_q[$];
    bit          m_trig = 0;
    logic [63:0] m_torder = '0;
    logic [63:0] m_last = '0;
    int          m_post = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic trace_rec_t cur_rec();
        trace_rec_t r;
        r.pc = pc; r.insn = insn; r.rd_addr = rd_addr;
        r.rd_wdata = rd_wdata; r.trap = trap; r.intr = intr;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_q.delete(); m_trig = 0; m_torder = '0; m_last = '0; m_post = 0;
    endtask

    task automatic model_push();
        m_q.push_back(cur_rec());
        m_last = order;
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
    endtask

    task automatic model_step();
        bit fire;
        if (abort) begin
            m_state = 0; m_q.delete(); m_trig = 0; m_torder = '0;
            return;
        end
        case (m_state)
            0: if (arm) begin
                m_state = 1; m_q.delete(); m_trig = 0; m_torder = '0; m_last = '0;
            end
            1: begin
                fire = frc || (valid && ((pc_en && pc == tpc) || (trap_en && trap)));
                if (fire) m_torder = valid ? order : m_last;
                if (valid) model_push();
                if (fire) begin
                    m_trig = 1; m_post = POST_TRIG;
                    m_state = (POST_TRIG == 0) ? 3 : 2;
                end
            end
            2: if (valid) begin
                model_push();
                m_post--;
                if (m_post == 0) m_state = 3;
            end
            default: begin
                if (m_q.size() == 0) m_state = 0;
                else if (ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_state = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        bit         ev;
        trace_rec_t ed;
        ev = (m_state == 3) && (m_q.size() != 0);
        ed = ev ? m_q[0] : '0;
        chk("state", state, m_state);
        chk("count", count, m_q.size());
        chk("triggered", triggered, m_trig);
        chk("trig_order", trig_order, m_torder);
        chk("done", done, m_state == 3);
        chk("rd_valid", rd_valid, ev);
        chk("rd_data", rd_data, ed);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        valid = 0; trap = 0; intr = 0; arm = 0; abort = 0; frc = 0; ready = 0;
    endtask

    task automatic retire(input logic [31:0] p, input logic [63:0] o, input bit t);
        valid = 1; pc = p; order = o; trap = t;
        insn = $urandom; rd_wdata = $urandom; rd_addr = 5'($urandom);
        intr = ($urandom % 4 == 0);
        cycle();
        valid = 0; trap = 0; intr = 0;
    endtask

    typedef struct {
        bit   arm, abort, frc, valid;
        int   exp_state, exp_count;
        bit   exp_trig;
    } vec_t;

    vec_t vecs[13];

    initial begin
        trace_rec_t  prev;
        bit          stalled;
        logic [31:0] got_pc[$];
        int          pat[6];

        vecs[0]  = '{1, 1, 0, 0, 0, 0, 0};  // arm+abort together stays IDLE
        vecs[1]  = '{0, 0, 0, 1, 0, 0, 0};  // retirement in IDLE ignored
        vecs[2]  = '{1, 0, 0, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 1, 1, 0};
        vecs[4]  = '{0, 0, 0, 1, 1, 2, 0};
        vecs[5]  = '{0, 0, 1, 0, 2, 2, 1};  // forced trigger, no write
        vecs[6]  = '{0, 1, 0, 0, 0, 0, 0};  // abort in POST
        vecs[7]  = '{1, 0, 0, 0, 1, 0, 0};
        vecs[8]  = '{0, 0, 1, 0, 2, 0, 1};
        vecs[9]  = '{0, 0, 0, 1, 2, 1, 1};
        vecs[10] = '{0, 0, 1, 1, 3, 2, 1};  // force ignored in POST; window closes
        vecs[11] = '{1, 0, 0, 0, 3, 2, 1};  // arm ignored in DONE
        vecs[12] = '{0, 1, 0, 0, 0, 0, 0};  // abort in DONE

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 0;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            arm = vecs[i].arm; abort = vecs[i].abort; frc = vecs[i].frc; valid = vecs[i].valid;
            pc = 32'h0000_1000 + 32'(4 * i); order = 64'(500 + i);
            cycle();
            chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            chk($sformatf("vec%0d_trig", i), triggered, vecs[i].exp_trig);
            clear_inputs();
        end
        cycle();

        // Basic capture
        pc_en = 1; tpc = 32'h0010_0088;
        arm = 1; cycle(); arm = 0;
        for (int k = 0; k < 10; k++) retire(32'h0010_0080 + 32'(4 * k), 64'(k), 0);
        chk("basic_state", state, 3);
        chk("basic_count", count, 5);
        chk("basic_torder", trig_order, 2);
        ready = 1;
        for (int k = 0; k < 5; k++) begin
            chk("basic_pc", rd_data.pc, 32'h0010_0080 + 32'(4 * k));
            cycle();
        end
        chk("basic_idle", state, 0);
        ready = 0;

        // Ring wrap
        tpc = 32'h0020_0000 + 32'(4 * 20);
        arm = 1; cycle(); arm = 0;
        for (int k = 0; k < 30; k++) retire(32'h0020_0000 + 32'(4 * k), 64'(100 + k), 0);
        chk("wrap_count", count, 8);
        chk("wrap_torder", trig_order, 120);
        ready = 1;
        for (int k = 15; k <= 22; k++) begin
            chk("wrap_pc", rd_data.pc, 32'h0020_0000 + 32'(4 * k));
            cycle();
        end
        chk("wrap_idle", state, 0);
        ready = 0;

        // Trap trigger with PC match disabled, then backpressured readout
        pc_en = 0; trap_en = 1; tpc = 32'h0030_0000 + 32'(4 * 3);
        arm = 1; cycle(); arm = 0;
        for (int o = 30; o <= 40; o++) begin
            retire(32'h0030_0000 + 32'(4 * (o - 30)), 64'(o), o == 37);
            if (o == 33) chk("trap_pcmatch_off", triggered, 0);
        end
        chk("trap_trig", triggered, 1);
        chk("trap_torder", trig_order, 37);
        chk("trap_count", count, 8);
        pat = '{1, 0, 0, 1, 0, 1};
        stalled = 0;
        prev = '0;
        for (int i = 0; i < 40 && state != 0; i++) begin
            ready = pat[i % 6][0];
            if (stalled) chk("stall_stable", rd_data, prev);
            if (rd_valid && ready) got_pc.push_back(rd_data.pc);
            stalled = rd_valid && !ready;
            prev = rd_data;
            cycle();
        end
        chk("bp_idle", state, 0);
        chk("bp_delivered", got_pc.size(), 8);
        for (int i = 0; i < got_pc.size() && i < 8; i++)
            chk("bp_pc", got_pc[i], 32'h0030_0000 + 32'(4 * (i + 2)));
        ready = 0; trap_en = 0;

        // Asynchronous reset mid-readout
        pc_en = 1; tpc = 32'h0010_0088;
        arm = 1; cycle(); arm = 0;
        for (int k = 0; k < 6; k++) retire(32'h0010_0080 + 32'(4 * k), 64'(k), 0);
        ready = 1; cycle(); ready = 0;
        #2 rst = 1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_count", count, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_done", done, 0);
        chk("arst_trig", triggered, 0);
        chk("arst_torder", trig_order, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        cycle();

        // Randomized traffic
        tpc = 32'h0040_0020;
        order = 64'd1000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pc_en = $urandom % 2; trap_en = $urandom % 2;
            end
            arm   = ($urandom % 15 == 0);
            abort = ($urandom % 150 == 0);
            frc   = ($urandom % 60 == 0);
            ready = ($urandom % 2 == 0);
            valid = ($urandom % 3 != 0);
            trap  = ($urandom % 30 == 0);
            intr  = ($urandom % 8 == 0);
            pc    = 32'h0040_0000 + 32'(4 * ($urandom % 24));
            insn = $urandom; rd_wdata = $urandom; rd_addr = 5'($urandom);
            order = order + 64'(valid);
            cycle();
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
